// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and default widths shared by the ALU exercise
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - purely combinational ALU; unknown opcodes yield zero
module alu_core
  import alu_pkg::*;
#(
  parameter int MAXTAM = DATA_W,
  parameter int tam_OP = OP_W
) (
  input  logic [MAXTAM-1:0] A,
  input  logic [MAXTAM-1:0] B,
  input  logic [tam_OP-1:0] OP,
  output logic [MAXTAM-1:0] result
);

  // Shift amounts at or beyond the data width saturate instead of wrapping.
  localparam logic [MAXTAM-1:0] SHIFT_LIM = MAXTAM[MAXTAM-1:0];

  logic shift_over;
  assign shift_over = (B >= SHIFT_LIM);

  always_comb begin
    result = '0;
    case (OP)
      tam_OP'(OP_ADD): result = A + B;
      tam_OP'(OP_SUB): result = A - B;
      tam_OP'(OP_AND): result = A & B;
      tam_OP'(OP_OR):  result = A | B;
      tam_OP'(OP_XOR): result = A ^ B;
      tam_OP'(OP_NOR): result = ~(A | B);
      tam_OP'(OP_SRA): result = shift_over ? {MAXTAM{A[MAXTAM-1]}}
                                           : MAXTAM'($signed(A) >>> B);
      tam_OP'(OP_SRL): result = shift_over ? '0 : (A >> B);
      default:         result = '0;
    endcase
  end

endmodule

// File: rtl/alu_top.sv
// rtl/alu_top.sv - button-loaded operand/opcode registers around alu_core
// Optional registered output: define ALU_OUT_REG_EN.
module alu_top
  import alu_pkg::*;
#(
  parameter int MAXTAM = DATA_W,
  parameter int tam_OP = OP_W
) (
  input  logic              clk,
  input  logic              btn_Reset,
  input  logic              btn_A,
  input  logic              btn_B,
  input  logic              btn_OP,
  input  logic [MAXTAM-1:0] In,
  output logic [MAXTAM-1:0] ALU_Out
);

  logic [MAXTAM-1:0] a;
  logic [MAXTAM-1:0] b;
  logic [tam_OP-1:0] op;
  logic [MAXTAM-1:0] result;

  // Buttons are plain level enables; holding one reloads every cycle.
  always_ff @(posedge clk or negedge btn_Reset) begin
    if (!btn_Reset) begin
      a  <= '0;
      b  <= '0;
      op <= '0;
    end else begin
      if (btn_A)  a  <= In;
      if (btn_B)  b  <= In;
      if (btn_OP) op <= In[tam_OP-1:0];
    end
  end

  alu_core #(
    .MAXTAM(MAXTAM),
    .tam_OP(tam_OP)
  ) u_core (
    .A      (a),
    .B      (b),
    .OP     (op),
    .result (result)
  );

`ifdef ALU_OUT_REG_EN
  logic [MAXTAM-1:0] out_q;

  always_ff @(posedge clk or negedge btn_Reset) begin
    if (!btn_Reset) out_q <= '0;
    else            out_q <= result;
  end

  assign ALU_Out = out_q;
`else
  assign ALU_Out = result;
`endif

endmodule

// File: tb/tb_alu_top.sv
// tb/tb_alu_top.sv - randomized and directed self-checking bench for alu_top
module tb_alu_top;

`ifdef ALU_OUT_REG_EN
  localparam bit REG_OUT = 1'b1;
`else
  localparam bit REG_OUT = 1'b0;
`endif

  logic       clk;
  logic       btn_Reset;
  logic       btn_A;
  logic       btn_B;
  logic       btn_OP;
  logic [7:0] In;
  logic [7:0] ALU_Out;

  int checks;
  int failures;

  int m_a, m_b, m_op, m_out;

  alu_top dut (
    .clk       (clk),
    .btn_Reset (btn_Reset),
    .btn_A     (btn_A),
    .btn_B     (btn_B),
    .btn_OP    (btn_OP),
    .In        (In),
    .ALU_Out   (ALU_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_alu(input int a, input int b, input int op);
    int sa, d;
    case (op)
      32: return (a + b) % 256;
      34: return (a - b + 256) % 256;
      36: return a & b;
      37: return a | b;
      38: return a ^ b;
      39: return 255 - (a | b);
      3: begin
        sa = (a >= 128) ? a - 256 : a;
        if (b >= 8) return (sa < 0) ? 255 : 0;
        d = 1 << b;
        sa = (sa >= 0) ? sa / d : -((-sa + d - 1) / d);
        return (sa + 256) % 256;
      end
      2: return (b >= 8) ? 0 : a / (1 << b);
      default: return 0;
    endcase
  endfunction

  function automatic int expected_out();
    return REG_OUT ? m_out : ref_alu(m_a, m_b, m_op);
  endfunction

  task automatic step(input string tag, input logic ba, input logic bb,
                      input logic bo, input logic [7:0] din);
    btn_A  = ba;
    btn_B  = bb;
    btn_OP = bo;
    In     = din;
    @(posedge clk);
    m_out = ref_alu(m_a, m_b, m_op);
    if (ba) m_a = din;
    if (bb) m_b = din;
    if (bo) m_op = din % 64;
    @(negedge clk);
    check(tag, ALU_Out, 8'(expected_out()));
  endtask

  task automatic load_and_check(input string tag, input logic [7:0] a,
                                input logic [7:0] b, input logic [5:0] op,
                                input logic [7:0] exp);
    step({tag, "_ldA"}, 1'b1, 1'b0, 1'b0, a);
    step({tag, "_ldB"}, 1'b0, 1'b1, 1'b0, b);
    step({tag, "_ldOP"}, 1'b0, 1'b0, 1'b1, {2'b00, op});
    step({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 8'h5a);
    check(tag, ALU_Out, exp);
  endtask

  initial begin
    int ops[8] = '{32, 34, 36, 37, 38, 39, 3, 2};
    int r;
    logic [7:0] din;
    checks = 0;
    failures = 0;
    m_a = 0; m_b = 0; m_op = 0; m_out = 0;
    btn_Reset = 1'b0;
    btn_A = 1'b0; btn_B = 1'b0; btn_OP = 1'b0;
    In = 8'hff;
    #3;
    check("reset_out", ALU_Out, 8'd0);
    @(negedge clk);
    @(negedge clk);
    check("reset_held", ALU_Out, 8'd0);
    btn_Reset = 1'b1;

    load_and_check("add", 8'd50, 8'd30, 6'b100000, 8'd80);
    load_and_check("sub", 8'd50, 8'd30, 6'b100010, 8'd20);
    load_and_check("and", 8'd50, 8'd30, 6'b100100, 8'd18);
    load_and_check("or",  8'd50, 8'd30, 6'b100101, 8'd62);
    load_and_check("xor", 8'd50, 8'd30, 6'b100110, 8'd44);
    load_and_check("nor", 8'd50, 8'd30, 6'b100111, 8'd193);
    load_and_check("sra2", 8'h80, 8'd2, 6'b000011, 8'he0);
    load_and_check("srl2", 8'h80, 8'd2, 6'b000010, 8'h20);
    load_and_check("sra9", 8'h80, 8'd9, 6'b000011, 8'hff);
    load_and_check("srl9", 8'h80, 8'd9, 6'b000010, 8'h00);
    load_and_check("sra8", 8'h40, 8'd8, 6'b000011, 8'h00);
    load_and_check("srl7", 8'hff, 8'd7, 6'b000010, 8'h01);
    load_and_check("add_wrap", 8'd200, 8'd100, 6'b100000, 8'd44);
    load_and_check("sub_wrap", 8'd10, 8'd20, 6'b100010, 8'd246);
    load_and_check("bad_op", 8'd10, 8'd20, 6'b111111, 8'd0);

    step("both_ld", 1'b1, 1'b1, 1'b0, 8'd7);
    step("both_op", 1'b0, 1'b0, 1'b1, 8'b00100000);
    step("both_idle", 1'b0, 1'b0, 1'b0, 8'd99);
    check("both_sum", ALU_Out, 8'd14);

    // Async reset between edges with valid operands loaded.
    #2 btn_Reset = 1'b0;
    #1 check("async_rst", ALU_Out, 8'd0);
    m_a = 0; m_b = 0; m_op = 0; m_out = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_hold", ALU_Out, 8'd0);
    btn_Reset = 1'b1;
    step("post_rst_op", 1'b0, 1'b0, 1'b1, 8'b00100000);
    step("post_rst_idle", 1'b0, 1'b0, 1'b0, 8'd3);
    check("no_restore", ALU_Out, 8'd0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      din = 8'($urandom);
      if (r < 3) din = (din < 128) ? 8'($urandom_range(0, 10)) : din;
      if ($urandom_range(0, 3) != 0 && r >= 7) din = 8'(ops[$urandom_range(0, 7)]);
      step("rand", 1'($urandom), 1'($urandom), r >= 7 ? 1'b1 : 1'($urandom_range(0, 7) == 0), din);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
